skolem_sweep_ctrl: RTL and testbench
====================================

SKOLEM_SWEEP_CTRL -- requirements
Module: skolem_sweep_ctrl

Interface
REQ-001 SHALL have parameter NX, default 8: width of the universal input vector applied to the Skolem function under test.
REQ-002 SHALL have parameter SETTLE, default 0: number of extra wait cycles per evaluation phase, range 0..15.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 start  in  1  sweep request; sampled only in IDLE or DONE.
REQ-006 fsk_x  out  NX  universal assignment driven to the Skolem function.
REQ-007 fsk_y  in  1  Skolem function output for fsk_x; combinational in the external logic.
REQ-008 phi_x  out  NX  universal assignment driven to the formula evaluator; always equals fsk_x.
REQ-009 phi_y  out  1  existential value driven to the formula evaluator.
REQ-010 phi_val  in  1  formula value phi(phi_x, phi_y).
REQ-011 busy  out  1  sweep in progress.
REQ-012 done  out  1  sweep finished; results are valid.
REQ-013 fail_cnt  out  NX+1  count of counterexample assignments.
REQ-014 unreal_cnt  out  NX+1  count of assignments where no existential value satisfies phi.
REQ-015 first_fail  out  NX  first counterexample assignment, valid when fail_cnt is nonzero.

Function
REQ-016 States SHALL be IDLE, CAND, ALT and DONE; busy=1 exactly in CAND and ALT, and done=1 exactly in DONE.
REQ-017 In IDLE or DONE with start=1, the block SHALL clear x, fail_cnt, unreal_cnt and first_fail, and enter CAND with x=0.
REQ-018 In CAND, phi_y SHALL equal fsk_y, and y_s SHALL capture fsk_y on every edge.
REQ-019 In ALT, phi_y SHALL equal ~y_s.
REQ-020 Each of CAND and ALT SHALL last SETTLE+1 cycles, counted by a phase counter; phi_val is sampled on the final edge of the phase.
REQ-021 When CAND samples phi_val=1, the assignment passes: if x equals 2^NX-1 the block SHALL enter DONE, otherwise it SHALL increment x and stay in CAND.
REQ-022 When CAND samples phi_val=0, the block SHALL enter ALT.
REQ-023 When ALT samples phi_val=1 (a counterexample), the block SHALL increment fail_cnt and, if fail_cnt was 0, load first_fail=x; it SHALL then advance or finish as in REQ-021.
REQ-024 When ALT samples phi_val=0 (unrealizable), the block SHALL increment unreal_cnt and then advance or finish as in REQ-021.
REQ-025 x SHALL never wrap: reaching 2^NX-1 always ends in DONE, and counters saturate at 2^NX.
REQ-026 start=1 while busy SHALL be ignored; start in DONE SHALL restart the sweep from x=0.
REQ-027 fsk_x/phi_x SHALL hold the current x in all states; in IDLE they are 0.

Reset
REQ-028 rst=1 SHALL, at the next edge, force IDLE, x=0, y_s=0, phase counter 0, fail_cnt=0, unreal_cnt=0, first_fail=0, busy=0 and done=0, including during a sweep.
REQ-029 rst SHALL take priority over start on the same edge.

Configuration
REQ-030 With SWEEP_STOP_ON_FAIL_EN defined, the first counterexample SHALL send the block directly to DONE, with fail_cnt=1 and first_fail set.
REQ-031 Without SWEEP_STOP_ON_FAIL_EN, the sweep SHALL always cover all 2^NX assignments.

Verification
REQ-032 NX=8, SETTLE=0, phi_val tied 1, start pulse -> busy for exactly 256 cycles, then done=1, fail_cnt=0, unreal_cnt=0.
REQ-033 NX=8, SETTLE=2, phi_val tied 1 -> done asserts 768 cycles after the start edge.
REQ-034 phi_val = (phi_y == ~fsk_y) -> every assignment fails; fail_cnt=256, first_fail=0, sweep length 512 cycles.
REQ-035 phi_val=0 only for x=0x5A (both phases) -> unreal_cnt=1, fail_cnt=0.
REQ-036 With SWEEP_STOP_ON_FAIL_EN, counterexample only at x=0x33 -> DONE after x=0x33 with fail_cnt=1 and first_fail=0x33; assert rst at x=0x80 in a second run -> next cycle IDLE with all outputs 0.

Source files
------------

// File: rtl/skolem_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : skolem_sweep_ctrl
// Brief    : Exhaustive sweep controller that checks a candidate Skolem
//            function against a formula phi(x, y). For each universal
//            assignment x, the candidate value y = f(x) is tried first (CAND);
//            if phi fails, the opposite y is tried (ALT) to tell a
//            counterexample apart from an unrealizable assignment.
// Options  : `define SWEEP_STOP_ON_FAIL_EN to finish the sweep at the first
//            counterexample.
// Revision : 1.0 - initial release
// ============================================================================
module skolem_sweep_ctrl #(
   parameter int NX     = 8,
   parameter int SETTLE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [NX-1:0] fsk_x,
   input  logic          fsk_y,
   output logic [NX-1:0] phi_x,
   output logic          phi_y,
   input  logic          phi_val,
   output logic          busy,
   output logic          done,
   output logic [NX:0]   fail_cnt,
   output logic [NX:0]   unreal_cnt,
   output logic [NX-1:0] first_fail
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CAND = 2'd1;
   localparam logic [1:0] S_ALT  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Last count of an evaluation phase; phases run SETTLE+1 cycles.
   localparam logic [3:0]  C_PHASE_LAST = 4'(SETTLE);
   // Counters never exceed the number of assignments, 2^NX.
   localparam logic [NX:0] C_CNT_MAX    = {1'b1, {NX{1'b0}}};

   logic [1:0]    r_state;
   logic [1:0]    w_next_state;
   logic [NX-1:0] r_x;
   logic          r_y_s;
   logic [3:0]    r_phase;
   logic [NX:0]   r_fail_cnt;
   logic [NX:0]   r_unreal_cnt;
   logic [NX-1:0] r_first_fail;

   logic w_in_phase;
   logic w_phase_end;
   logic w_x_last;
   logic w_start_ok;
   logic w_cand_pass;
   logic w_alt_end;
   logic w_cex;
   logic w_unreal;
   logic w_stop;
   logic w_advance;

   assign w_in_phase  = (r_state == S_CAND) || (r_state == S_ALT);
   assign w_phase_end = w_in_phase && (r_phase == C_PHASE_LAST);
   assign w_x_last    = &r_x;
   assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_cand_pass = (r_state == S_CAND) && w_phase_end && phi_val;
   assign w_alt_end   = (r_state == S_ALT) && w_phase_end;
   assign w_cex       = w_alt_end && phi_val;
   assign w_unreal    = w_alt_end && !phi_val;

`ifdef SWEEP_STOP_ON_FAIL_EN
   // A counterexample terminates the sweep immediately.
   assign w_stop = w_cex;
`else
   assign w_stop = 1'b0;
`endif

   // x moves on only when the assignment is resolved and the sweep continues.
   assign w_advance = (w_cand_pass || w_alt_end) && !w_x_last && !w_stop;

   assign fsk_x      = r_x;
   assign phi_x      = r_x;
   assign fail_cnt   = r_fail_cnt;
   assign unreal_cnt = r_unreal_cnt;
   assign first_fail = r_first_fail;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decision from phase completion and the sampled phi value.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_next_state = S_CAND;
            end
         end
         S_CAND: begin
            if (w_phase_end) begin
               if (!phi_val) begin
                  w_next_state = S_ALT;
               end else if (w_x_last) begin
                  w_next_state = S_DONE;
               end
            end
         end
         S_ALT: begin
            if (w_phase_end) begin
               if (w_x_last || w_stop) begin
                  w_next_state = S_DONE;
               end else begin
                  w_next_state = S_CAND;
               end
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Moore outputs: status flags and the existential value shown to phi.
   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      phi_y = 1'b0;
      case (r_state)
         S_CAND: begin
            busy  = 1'b1;
            phi_y = fsk_y;
         end
         S_ALT: begin
            busy  = 1'b1;
            phi_y = ~r_y_s;
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Sweep datapath: assignment, phase timer, captured candidate and results.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x          <= '0;
         r_y_s        <= 1'b0;
         r_phase      <= '0;
         r_fail_cnt   <= '0;
         r_unreal_cnt <= '0;
         r_first_fail <= '0;
      end else if (w_start_ok) begin
         r_x          <= '0;
         r_phase      <= '0;
         r_fail_cnt   <= '0;
         r_unreal_cnt <= '0;
         r_first_fail <= '0;
      end else begin
         if (r_state == S_CAND) begin
            r_y_s <= fsk_y;
         end
         if (w_in_phase && !w_phase_end) begin
            r_phase <= r_phase + 4'd1;
         end else begin
            r_phase <= '0;
         end
         if (w_cex) begin
            if (r_fail_cnt == '0) begin
               r_first_fail <= r_x;
            end
            if (r_fail_cnt != C_CNT_MAX) begin
               r_fail_cnt <= r_fail_cnt + (NX+1)'(1);
            end
         end
         if (w_unreal && (r_unreal_cnt != C_CNT_MAX)) begin
            r_unreal_cnt <= r_unreal_cnt + (NX+1)'(1);
         end
         if (w_advance) begin
            r_x <= r_x + NX'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_skolem_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_skolem_sweep_ctrl
// Brief    : Scoreboard bench for skolem_sweep_ctrl. Two instances (SETTLE=0
//            and SETTLE=2) share start/rst and a randomized Skolem function /
//            formula table. Expected sweep results come from a table-driven
//            reference model; a monitor per instance checks them at done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skolem_sweep_ctrl;

   localparam int NX = 8;
   localparam int N  = 1 << NX;

   typedef struct {
      int fail;
      int unreal;
      int first;
      int cycles;
      int last_x;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;

   // External logic: f(x) and phi(x, y) as lookup tables; p_tab[x][y] = phi.
   logic       f_tab [N];
   logic [1:0] p_tab [N];

   int n_chk  = 0;
   int n_pass = 0;

   exp_t qa[$];
   exp_t qb[$];

   // Instance A: SETTLE = 0.
   logic [NX-1:0] a_fsk_x, a_phi_x, a_first;
   logic          a_fsk_y, a_phi_y, a_phi_val, a_busy, a_done;
   logic [NX:0]   a_fail, a_unreal;

   // Instance B: SETTLE = 2.
   logic [NX-1:0] b_fsk_x, b_phi_x, b_first;
   logic          b_fsk_y, b_phi_y, b_phi_val, b_busy, b_done;
   logic [NX:0]   b_fail, b_unreal;

   assign a_fsk_y   = f_tab[a_fsk_x];
   assign a_phi_val = p_tab[a_phi_x][a_phi_y];
   assign b_fsk_y   = f_tab[b_fsk_x];
   assign b_phi_val = p_tab[b_phi_x][b_phi_y];

   always #5 clk = ~clk;

   skolem_sweep_ctrl #(.NX(NX), .SETTLE(0)) u_dut_a (
      .clk(clk), .rst(rst), .start(start),
      .fsk_x(a_fsk_x), .fsk_y(a_fsk_y), .phi_x(a_phi_x), .phi_y(a_phi_y),
      .phi_val(a_phi_val), .busy(a_busy), .done(a_done),
      .fail_cnt(a_fail), .unreal_cnt(a_unreal), .first_fail(a_first)
   );

   skolem_sweep_ctrl #(.NX(NX), .SETTLE(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start),
      .fsk_x(b_fsk_x), .fsk_y(b_fsk_y), .phi_x(b_phi_x), .phi_y(b_phi_y),
      .phi_val(b_phi_val), .busy(b_busy), .done(b_done),
      .fail_cnt(b_fail), .unreal_cnt(b_unreal), .first_fail(b_first)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", nm, act, exp);
   endtask

   // Reference: classify every assignment from the tables alone.
   function automatic exp_t model(input int settle);
      exp_t e;
      e = '{default: 0};
      for (int x = 0; x < N; x++) begin
         logic yc;
         yc = f_tab[x];
         e.last_x = x;
         if (p_tab[x][yc]) begin
            e.cycles += settle + 1;
         end else begin
            e.cycles += 2 * (settle + 1);
            if (p_tab[x][!yc]) begin
               if (e.fail == 0) e.first = x;
               e.fail++;
`ifdef SWEEP_STOP_ON_FAIL_EN
               break;
`endif
            end else begin
               e.unreal++;
            end
         end
      end
      return e;
   endfunction

   // Table patterns: 0 all pass, 1 all fail, 2 unreal at 0x5A,
   // 3 random, 4 single counterexample at 0x33.
   task automatic set_tabs(input int mode);
      for (int x = 0; x < N; x++) begin
         f_tab[x] = 1'($urandom_range(0, 1));
         case (mode)
            1:       p_tab[x] = f_tab[x] ? 2'b01 : 2'b10;
            2:       p_tab[x] = (x == 'h5A) ? 2'b00 : 2'b11;
            3:       p_tab[x] = 2'($urandom_range(0, 3));
            4:       p_tab[x] = (x == 'h33) ? (f_tab[x] ? 2'b01 : 2'b10) : 2'b11;
            default: p_tab[x] = 2'b11;
         endcase
      end
   endtask

   // Monitor A: count busy cycles and score results when done rises.
   int   a_bc = 0;
   int   a_inv = 0;
   logic a_pd = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         a_bc = 0;
      end else begin
         if (a_busy) a_bc++;
         if ((a_busy && a_done) || (a_phi_x !== a_fsk_x)) a_inv++;
         if (a_done && !a_pd) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = qa.pop_front();
               chk("a_fail_cnt", a_fail, e.fail);
               chk("a_unreal_cnt", a_unreal, e.unreal);
               chk("a_first_fail", a_first, e.first);
               chk("a_busy_cycles", a_bc, e.cycles);
               chk("a_final_x", a_fsk_x, e.last_x);
               chk("a_invariants", a_inv, 0);
            end
            a_bc = 0;
         end
      end
      a_pd = a_done;
   end

   // Monitor B: same scoring for the SETTLE=2 instance.
   int   b_bc = 0;
   int   b_inv = 0;
   logic b_pd = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         b_bc = 0;
      end else begin
         if (b_busy) b_bc++;
         if ((b_busy && b_done) || (b_phi_x !== b_fsk_x)) b_inv++;
         if (b_done && !b_pd) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = qb.pop_front();
               chk("b_fail_cnt", b_fail, e.fail);
               chk("b_unreal_cnt", b_unreal, e.unreal);
               chk("b_first_fail", b_first, e.first);
               chk("b_busy_cycles", b_bc, e.cycles);
               chk("b_final_x", b_fsk_x, e.last_x);
               chk("b_invariants", b_inv, 0);
            end
            b_bc = 0;
         end
      end
      b_pd = b_done;
   end

   task automatic run_sweep(input int mode, input string nm);
      int t;
      set_tabs(mode);
      qa.push_back(model(0));
      qb.push_back(model(2));
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      t = 0;
      while (!(a_done && b_done) && t < 4000) begin
         @(posedge clk); #1;
         t++;
         // A start pulse mid-sweep must be ignored.
         start = (t == 10);
      end
      start = 1'b0;
      chk({nm, "_done_in_time"}, (t < 4000), 1);
      @(negedge clk);
      @(negedge clk);
      chk({nm, "_qa_drained"}, qa.size(), 0);
      chk({nm, "_qb_drained"}, qb.size(), 0);
      qa.delete();
      qb.delete();
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_a_busy"},   a_busy,   0);
      chk({nm, "_a_done"},   a_done,   0);
      chk({nm, "_a_fail"},   a_fail,   0);
      chk({nm, "_a_unreal"}, a_unreal, 0);
      chk({nm, "_a_first"},  a_first,  0);
      chk({nm, "_a_x"},      a_fsk_x,  0);
      chk({nm, "_a_phi_x"},  a_phi_x,  0);
      chk({nm, "_a_phi_y"},  a_phi_y,  0);
      chk({nm, "_b_busy"},   b_busy,   0);
      chk({nm, "_b_done"},   b_done,   0);
      chk({nm, "_b_x"},      b_fsk_x,  0);
   endtask

   initial begin
      int t;
      set_tabs(0);
      repeat (3) @(posedge clk);
      #1 chk_idle("reset");
      rst = 1'b0;

      run_sweep(0, "all_pass");
      run_sweep(1, "all_fail");
      run_sweep(2, "unreal_5a");
      run_sweep(4, "cex_33");
      run_sweep(3, "rand0");
      run_sweep(3, "rand1");
      run_sweep(3, "rand2");

      // Reset in the middle of a sweep.
      set_tabs(0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      t = 0;
      while (a_fsk_x != 8'h80 && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("mid_reach_80", (t < 1000), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_idle("mid_reset");

      // Reset wins over start on the same edge.
      start = 1'b1;
      @(posedge clk); #1;
      chk("rst_prio_a_busy", a_busy, 0);
      chk("rst_prio_b_busy", b_busy, 0);
      rst = 1'b0;
      start = 1'b0;

      run_sweep(3, "from_idle");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
